// File: rtl/sensor_responder_pkg.sv
// Shared definitions for the sensor responder and the arbiter that talks to it:
// frame constants and the responder FSM encoding.
package sensor_responder_pkg;

  localparam logic [7:0] SR_CHECKSUM_KEY = 8'h37;
  localparam logic [7:0] SR_ALARM_BASE   = 8'hA0;

  // Channel index width; covers up to 15 sensors.
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SEND_VAL = 3'd2,
    ST_WAIT_VAL = 3'd3,
    ST_SEND_CHK = 3'd4,
    ST_WAIT_CHK = 3'd5
  } state_e;

endpackage

// File: rtl/sensor_alarm_queue.sv
// Alarm edge detector with a pending flag per channel and a lowest-index-first
// priority encoder selecting the next alarm to report.
module sensor_alarm_queue
  import sensor_responder_pkg::*;
#(
  parameter int N_SENSORS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_SENSORS-1:0] alarm_i,
  input  logic                 clr_i,
  input  logic [IDX_W-1:0]     clr_idx_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [N_SENSORS-1:0] prev_q;
  logic [N_SENSORS-1:0] pending_q;
  logic [N_SENSORS-1:0] pending_d;
  logic [N_SENSORS-1:0] rise;
  logic [N_SENSORS-1:0] clr_mask;
  logic                 armed_q;

  // The first cycle after reset only loads the history, so a level already
  // high at release is not mistaken for an edge. A new edge wins over a clear.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (clr_i && (clr_idx_i == IDX_W'(i))) clr_mask[i] = 1'b1;
    end
    rise      = armed_q ? (alarm_i & ~prev_q) : '0;
    pending_d = (pending_q & ~clr_mask) | rise;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q    <= '0;
      pending_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      prev_q    <= alarm_i;
      pending_q <= pending_d;
      armed_q   <= 1'b1;
    end
  end

  always_comb begin
    valid_o = |pending_q;
    idx_o   = '0;
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (pending_q[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/sensor_responder.sv
// Answers single-byte sensor requests and pending alarms with a two-byte frame
// (value, value ^ key) handed to an external UART transmitter.
module sensor_responder
  import sensor_responder_pkg::*;
#(
  parameter int         N_SENSORS    = 8,
  parameter logic [7:0] CHECKSUM_KEY = SR_CHECKSUM_KEY,
  parameter logic [7:0] ALARM_BASE   = SR_ALARM_BASE
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_dv,
  input  logic [7:0]             rx_byte,
  input  logic                   tx_done,
  input  logic [8*N_SENSORS-1:0] sensor_data,
  input  logic [N_SENSORS-1:0]   sensor_alarm,
  output logic                   tx_dv,
  output logic [7:0]             tx_byte,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);

  localparam logic [7:0] MAX_ID = 8'(N_SENSORS);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             alarm_frame_q, alarm_frame_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       drop_q, drop_d;

  logic             req_ok;
  logic             alarm_vld;
  logic             alarm_clr;
  logic [IDX_W-1:0] alarm_idx;
  logic [7:0]       sensor_val;
  logic [7:0]       frame_val;

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  assign req_ok    = rx_dv && (rx_byte != 8'h00) && (rx_byte <= MAX_ID);
  assign alarm_clr = (state_q == ST_LOAD) && alarm_frame_q;

  sensor_alarm_queue #(
    .N_SENSORS (N_SENSORS)
  ) u_alarm_queue (
    .clk_i     (clock),
    .rst_i     (reset),
    .alarm_i   (sensor_alarm),
    .clr_i     (alarm_clr),
    .clr_idx_i (sel_q),
    .valid_o   (alarm_vld),
    .idx_o     (alarm_idx)
  );

  always_comb begin
    sensor_val = 8'h00;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (sel_q == IDX_W'(i)) sensor_val = sensor_data[8*i +: 8];
    end
    frame_val = alarm_frame_q
              ? (ALARM_BASE | {{(8-IDX_W){1'b0}}, sel_q + IDX_W'(1)})
              : sensor_val;
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    alarm_frame_d = alarm_frame_q;
    drop_d        = drop_q;
    tx_dv         = 1'b0;
    busy          = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        // A valid request beats a pending alarm; the alarm stays queued.
        if (req_ok) begin
          state_d       = ST_LOAD;
          sel_d         = rx_byte[IDX_W-1:0] - IDX_W'(1);
          alarm_frame_d = 1'b0;
        end else begin
          if (rx_dv) drop_d = sat_inc8(drop_q);
          if (alarm_vld) begin
            state_d       = ST_LOAD;
            sel_d         = alarm_idx;
            alarm_frame_d = 1'b1;
          end
        end
      end
      ST_LOAD:     state_d = ST_SEND_VAL;
      ST_SEND_VAL: begin
        tx_dv   = 1'b1;
        state_d = ST_WAIT_VAL;
      end
      ST_WAIT_VAL: if (tx_done) state_d = ST_SEND_CHK;
      ST_SEND_CHK: begin
        tx_dv   = 1'b1;
        state_d = ST_WAIT_CHK;
      end
      ST_WAIT_CHK: if (tx_done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && rx_dv) drop_d = sat_inc8(drop_q);
  end

  // Value and checksum are captured together in LOAD so the frame is immune
  // to sensor changes while it is on the wire.
  always_comb begin
    tx_byte_d = tx_byte_q;
    chk_d     = chk_q;
    if (state_q == ST_LOAD) begin
      tx_byte_d = frame_val;
      chk_d     = frame_val ^ CHECKSUM_KEY;
    end else if ((state_q == ST_WAIT_VAL) && tx_done) begin
      tx_byte_d = chk_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      alarm_frame_q <= 1'b0;
      tx_byte_q     <= 8'h00;
      drop_q        <= 8'h00;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      alarm_frame_q <= alarm_frame_d;
      tx_byte_q     <= tx_byte_d;
      drop_q        <= drop_d;
    end
  end

  always_ff @(posedge clock) begin
    chk_q <= chk_d;
  end

  assign tx_byte  = tx_byte_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_sensor_responder.sv
// Bench for sensor_responder: vector table, directed corner sequences and a
// randomized run against a cycle-budget reference model.
module tb_sensor_responder;

  localparam int         N    = 8;
  localparam int         G    = 3;
  localparam logic [7:0] KEY  = 8'h37;
  localparam logic [7:0] BASE = 8'hA0;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           rx_dv = 1'b0;
  logic [7:0]     rx_byte = 8'h00;
  logic           tx_done = 1'b0;
  logic [8*N-1:0] sensor_data = '0;
  logic [N-1:0]   sensor_alarm = '0;
  logic           tx_dv;
  logic [7:0]     tx_byte;
  logic           busy;
  logic [7:0]     drop_cnt;

  int         n_chk = 0;
  int         n_pass = 0;
  int         rcnt = 0;
  logic       spur = 1'b0;
  logic [7:0] last_tx = 8'h00;
  logic [7:0] txq[$];
  logic [7:0] expq[$];
  int         exp_drop;

  typedef struct {
    logic [7:0] id;
    logic [7:0] sval;
    logic       frame;
    logic [7:0] ev;
    logic [7:0] ec;
    logic [7:0] edrop;
  } vec_t;

  vec_t vt[8];

  int             free_at, load_at, load_sel, mdrop, lidx;
  logic           load_alarm, rv, armed, idle;
  logic [7:0]     pend, prev_al, al, rb, v, clr;
  logic [8*N-1:0] sd;

  sensor_responder #(.N_SENSORS(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_dv        (rx_dv),
    .rx_byte      (rx_byte),
    .tx_done      (tx_done),
    .sensor_data  (sensor_data),
    .sensor_alarm (sensor_alarm),
    .tx_dv        (tx_dv),
    .tx_byte      (tx_byte),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check32(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [7:0] qget(input int i);
    if (i < txq.size()) return txq[i];
    return 8'hxx;
  endfunction

  task automatic pulse_rx(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    check1("idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_frames(input int nbytes, input int budget);
    int k = 0;
    while (txq.size() < nbytes && k < budget) begin
      tick();
      k++;
    end
    check1("frame_timeout", txq.size() >= nbytes, 1'b1);
    wait_idle(100);
  endtask

  // UART transmitter stand-in: records each byte and answers tx_done G cycles later.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      tx_done = 1'b0;
      if (reset) rcnt = 0;
      else if (tx_dv === 1'b1) begin
        txq.push_back(tx_byte);
        last_tx = tx_byte;
        rcnt = G;
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          tx_done = 1'b1;
          check8("tx_hold", tx_byte, last_tx);
        end
      end
      if (spur) begin
        tx_done = 1'b1;
        spur = 1'b0;
      end
    end
  end

  initial begin
    vt[0] = '{8'h03, 8'h5A, 1'b1, 8'h5A, 8'h6D, 8'd0};
    vt[1] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'd1};
    vt[2] = '{8'h09, 8'h00, 1'b0, 8'h00, 8'h00, 8'd2};
    vt[3] = '{8'h01, 8'h00, 1'b1, 8'h00, 8'h37, 8'd2};
    vt[4] = '{8'h08, 8'hFF, 1'b1, 8'hFF, 8'hC8, 8'd2};
    vt[5] = '{8'h05, 8'h37, 1'b1, 8'h37, 8'h00, 8'd2};
    vt[6] = '{8'h0F, 8'h00, 1'b0, 8'h00, 8'h00, 8'd3};
    vt[7] = '{8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 8'd4};

    // Reset state
    #2;
    reset = 1'b1;
    tick();
    tick();
    check1("rst_tx_dv", tx_dv, 1'b0);
    check8("rst_tx_byte", tx_byte, 8'h00);
    check1("rst_busy", busy, 1'b0);
    check8("rst_drop", drop_cnt, 8'h00);
    reset = 1'b0;
    tick();
    tick();

    // Vector table: single requests and invalid IDs
    for (int i = 0; i < 8; i++) begin
      txq.delete();
      if (vt[i].frame) sensor_data[8*(int'(vt[i].id)-1) +: 8] = vt[i].sval;
      pulse_rx(vt[i].id);
      check1("lat1_tx_dv", tx_dv, 1'b0);
      tick();
      check1("lat2_tx_dv", tx_dv, vt[i].frame);
      if (vt[i].frame) check8("lat2_tx_byte", tx_byte, vt[i].ev);
      wait_idle(100);
      tick();
      tick();
      check32("vec_frame_len", txq.size(), vt[i].frame ? 2 : 0);
      if (vt[i].frame) begin
        check8("vec_val", qget(0), vt[i].ev);
        check8("vec_chk", qget(1), vt[i].ec);
      end
      check1("vec_busy_end", busy, 1'b0);
      check8("vec_drop", drop_cnt, vt[i].edrop);
    end
    exp_drop = 4;

    // Value is sampled in the cycle after rx_dv, not before or after
    txq.delete();
    sensor_data[23:16] = 8'h11;
    pulse_rx(8'h03);
    sensor_data[23:16] = 8'h22;
    tick();
    sensor_data[23:16] = 8'h33;
    check8("sample_val", tx_byte, 8'h22);
    wait_idle(100);
    tick();
    check8("sample_chk", qget(1), 8'h15);

    // Request during WAIT_VAL is dropped
    txq.delete();
    sensor_data[23:16] = 8'h5A;
    sensor_data[31:24] = 8'h44;
    pulse_rx(8'h03);
    tick();
    tick();
    check1("busy_in_wait_val", busy, 1'b1);
    pulse_rx(8'h04);
    exp_drop++;
    wait_idle(100);
    repeat (15) tick();
    check32("busydrop_len", txq.size(), 2);
    check8("busydrop_val", qget(0), 8'h5A);
    check8("busydrop_chk", qget(1), 8'h6D);
    check8("busydrop_cnt", drop_cnt, 8'(exp_drop));

    // Request coinciding with the final tx_done is dropped
    txq.delete();
    pulse_rx(8'h03);
    repeat (2 + 2*G) tick();
    check1("final_done_busy", busy, 1'b1);
    pulse_rx(8'h04);
    exp_drop++;
    repeat (15) tick();
    check32("final_done_len", txq.size(), 2);
    check8("final_done_cnt", drop_cnt, 8'(exp_drop));
    check1("final_done_idle", busy, 1'b0);

    // Stray tx_done in IDLE
    spur = 1'b1;
    repeat (3) tick();
    check1("spur_tx_dv", tx_dv, 1'b0);
    check1("spur_busy", busy, 1'b0);
    check32("spur_len", txq.size(), 2);

    // Two alarms rise with a request in the same cycle
    txq.delete();
    sensor_data[15:8] = 8'hC3;
    sensor_alarm[5] = 1'b1;
    sensor_alarm[1] = 1'b1;
    pulse_rx(8'h02);
    wait_frames(6, 300);
    repeat (20) tick();
    check32("arb_len", txq.size(), 6);
    check8("arb_b0", qget(0), 8'hC3);
    check8("arb_b1", qget(1), 8'hF4);
    check8("arb_b2", qget(2), 8'hA2);
    check8("arb_b3", qget(3), 8'h95);
    check8("arb_b4", qget(4), 8'hA6);
    check8("arb_b5", qget(5), 8'h91);
    sensor_alarm = '0;
    tick();

    // Reset during WAIT_CHK aborts the frame
    txq.delete();
    sensor_data[23:16] = 8'h5A;
    pulse_rx(8'h03);
    repeat (G + 3) tick();
    check1("midrst_pre_busy", busy, 1'b1);
    check8("midrst_pre_byte", tx_byte, 8'h6D);
    reset = 1'b1;
    #1;
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_tx_dv", tx_dv, 1'b0);
    check8("midrst_drop", drop_cnt, 8'h00);
    check8("midrst_tx_byte", tx_byte, 8'h00);
    exp_drop = 0;
    tick();
    tick();
    reset = 1'b0;
    repeat (20) tick();
    check32("midrst_len", txq.size(), 2);
    check1("midrst_post_busy", busy, 1'b0);

    // Alarm already high at reset release is not an edge
    txq.delete();
    reset = 1'b1;
    sensor_alarm[3] = 1'b1;
    tick();
    reset = 1'b0;
    repeat (15) tick();
    check32("rstlvl_len", txq.size(), 0);
    check1("rstlvl_busy", busy, 1'b0);
    sensor_alarm[3] = 1'b0;
    tick();
    sensor_alarm[3] = 1'b1;
    wait_frames(2, 50);
    repeat (3) tick();
    check32("rearm_len", txq.size(), 2);
    check8("rearm_val", qget(0), 8'hA4);
    check8("rearm_chk", qget(1), 8'h93);
    sensor_alarm = '0;
    tick();

    // drop_cnt saturation
    repeat (254) pulse_rx(8'h00);
    check8("sat_254", drop_cnt, 8'hFE);
    pulse_rx(8'h00);
    check8("sat_255", drop_cnt, 8'hFF);
    repeat (45) pulse_rx(8'h00);
    check8("sat_300", drop_cnt, 8'hFF);

    // Randomized run against the reference model
    reset = 1'b1;
    sensor_alarm = '0;
    tick();
    tick();
    reset = 1'b0;
    txq.delete();
    expq.delete();
    free_at = 0; load_at = -1; load_sel = 0; load_alarm = 1'b0;
    pend = 8'h00; prev_al = 8'h00; al = 8'h00; armed = 1'b0; mdrop = 0;
    for (int c = 0; c < 1800; c++) begin
      idle = (c >= free_at);
      check1("rnd_busy", busy, !idle);
      check8("rnd_drop", drop_cnt, 8'(mdrop));
      if (c < 1500) begin
        rv = ($urandom_range(0, 5) == 0);
        rb = 8'($urandom_range(0, 10));
        if ($urandom_range(0, 7) == 0) al = al ^ 8'(1 << $urandom_range(0, 7));
      end else begin
        rv = 1'b0;
        rb = 8'h00;
        al = 8'h00;
      end
      sd = {$urandom(), $urandom()};
      rx_dv = rv;
      rx_byte = rb;
      sensor_alarm = al;
      sensor_data = sd;

      clr = 8'h00;
      if (load_at == c) begin
        if (load_alarm) begin
          v = BASE | 8'(load_sel + 1);
          clr = 8'(1 << load_sel);
        end else begin
          v = sd[8*load_sel +: 8];
        end
        expq.push_back(v);
        expq.push_back(v ^ KEY);
      end
      if (idle && rv && rb >= 1 && rb <= N) begin
        load_at = c + 1; load_alarm = 1'b0; load_sel = int'(rb) - 1;
        free_at = c + 4 + 2*G;
      end else begin
        if (rv) mdrop = (mdrop < 255) ? mdrop + 1 : 255;
        if (idle && pend != 8'h00) begin
          lidx = -1;
          for (int i = N - 1; i >= 0; i--) if (pend[i]) lidx = i;
          load_at = c + 1; load_alarm = 1'b1; load_sel = lidx;
          free_at = c + 4 + 2*G;
        end
      end
      pend = (pend & ~clr) | (armed ? (al & ~prev_al) : 8'h00);
      prev_al = al;
      armed = 1'b1;
      tick();
    end
    rx_dv = 1'b0;
    check32("rnd_len", txq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) check8("rnd_byte", qget(i), expq[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sensor_responder.md
SENSOR_RESPONDER -- requirements
Module: sensor_responder

Interface
REQ-001 SHALL have parameter N_SENSORS, default 8, number of sensor channels (1..15).
REQ-002 SHALL have parameter CHECKSUM_KEY, default 8'h37, XOR key shared with the arbiter.
REQ-003 SHALL have parameter ALARM_BASE, default 8'hA0, upper nibble of the alarm frame value byte.
REQ-004 clock  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx_dv  input  1  one-cycle pulse; rx_byte holds a received request byte.
REQ-007 rx_byte  input  8  request byte from the UART receiver.
REQ-008 tx_done  input  1  one-cycle pulse from the UART transmitter when a byte has finished.
REQ-009 sensor_data  input  8*N_SENSORS  current value of sensor i in bits [8i+7:8i].
REQ-010 sensor_alarm  input  N_SENSORS  level alarm flag per sensor.
REQ-011 tx_dv  output  1  one-cycle pulse starting transmission of tx_byte.
REQ-012 tx_byte  output  8  byte to transmit; stable from the tx_dv cycle until the matching tx_done.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 drop_cnt  output  8  count of ignored requests (busy, zero or out-of-range ID); saturates at 8'hFF.

Function
REQ-015 Request byte k with 1 <= k <= N_SENSORS SHALL select sensor k-1.
- Byte 8'h00 or k > N_SENSORS: no response; drop_cnt increments.
REQ-016 A response frame SHALL be two bytes: value V first, then checksum C = V ^ CHECKSUM_KEY.
REQ-017 V SHALL be sampled from sensor_data in the cycle after rx_dv and held for the whole frame.
REQ-018 FSM states SHALL be IDLE, LOAD, SEND_VAL, WAIT_VAL, SEND_CHK, WAIT_CHK.
- IDLE->LOAD: valid request, or alarm pending.
- LOAD->SEND_VAL: unconditional, one cycle; latches V and C.
- SEND_VAL->WAIT_VAL: tx_dv=1 for exactly this cycle, tx_byte=V.
- WAIT_VAL->SEND_CHK: on tx_done.
- SEND_CHK->WAIT_CHK: tx_dv=1, tx_byte=C.
- WAIT_CHK->IDLE: on tx_done.
REQ-019 Latency SHALL be exactly 2 clocks, from the rx_dv cycle to the first tx_dv cycle.
REQ-020 A request arriving while busy=1 SHALL be discarded and increment drop_cnt; no queueing.
REQ-021 A rising edge of sensor_alarm[i] SHALL set pending[i].
- A level held high does not re-arm.
- A rising edge on an already pending channel is absorbed.
REQ-022 An alarm frame SHALL use V = ALARM_BASE | (i+1) and C = V ^ CHECKSUM_KEY.
- pending[i] clears in the LOAD cycle of that frame.
REQ-023 Alarms SHALL be served lowest index first.
- rx_dv with a valid ID in IDLE in the same cycle as a pending alarm: the request wins and the alarm stays pending.
REQ-024 tx_done outside WAIT_VAL/WAIT_CHK SHALL be ignored.
REQ-025 rx_dv arriving in the same cycle as the final tx_done SHALL count as busy and be dropped.
REQ-026 drop_cnt SHALL hold at 8'hFF; it does not wrap.

Reset
REQ-027 Reset SHALL asynchronously force the following:
- state=IDLE, tx_dv=0, tx_byte=8'h00, busy=0, drop_cnt=0.
- pending and the alarm edge-detect history cleared.
REQ-028 Reset mid-frame SHALL abort the frame; no further tx_dv until a new request or alarm edge after release.
REQ-029 An alarm level already high at reset release SHALL NOT count as an edge.

Structure
REQ-030 A shared package SHALL hold CHECKSUM_KEY, ALARM_BASE and the FSM state encoding.
- The arbiter and this block use the same package.
REQ-031 One sub-module SHALL be natural: sensor_alarm_queue.
- Contains edge detect, pending register and lowest-index priority encoder.
- Outputs a valid flag and the channel index.
REQ-032 The block SHALL NOT contain the UART.
- Its ports connect to existing uart_rx/uart_tx instances at top level.

Verification
REQ-033 Bench SHALL cover single request.
- Stimulus: sensor_data[2]=8'h5A; rx_byte=8'h03 with rx_dv.
- Required: tx_dv 2 clocks later with tx_byte=8'h5A; after tx_done, tx_byte=8'h6D; busy=0 after second tx_done.
REQ-034 Bench SHALL cover invalid IDs.
- Stimulus: rx_byte=8'h00, then 8'h09 (N_SENSORS=8).
- Required: no tx_dv; drop_cnt=2.
REQ-035 Bench SHALL cover a busy drop.
- Stimulus: second valid request during WAIT_VAL.
- Required: first frame completes unchanged; no second frame; drop_cnt +1.
REQ-036 Bench SHALL cover alarm arbitration.
- Stimulus: sensor_alarm[5] and [1] rise together; a request arrives the same cycle.
- Required order: request frame, then 8'hA2/8'h95, then 8'hA6/8'h91.
REQ-037 Bench SHALL cover reset mid-frame.
- Stimulus: assert reset during WAIT_CHK.
- Required: immediate IDLE, tx_dv=0, drop_cnt=0; no checksum byte sent after release.
REQ-038 Bench SHALL cover saturation.
- Stimulus: 300 zero-ID requests.
- Required: drop_cnt=8'hFF.
